// File: rtl/image_bram_scheduler_if.sv
// Request/grant bus between the image loader, the two processing readers and the BRAM scheduler.
// master = loader/reader side, slave = scheduler side.
interface image_bram_scheduler_if #(
  parameter int ADDR_W = 20
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              load_finished;
  logic              wr_gnt;
  logic              rd0_req;
  logic [ADDR_W-1:0] rd0_addr;
  logic              rd1_req;
  logic [ADDR_W-1:0] rd1_addr;
  logic              rd0_gnt;
  logic              rd1_gnt;
  logic              rd0_valid;
  logic              rd1_valid;
  logic [23:0]       rd_data;
  logic              proc_done;

  modport master (
    output wr_req, wr_addr, wr_data, load_finished,
    output rd0_req, rd0_addr, rd1_req, rd1_addr, proc_done,
    input  wr_gnt, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid, rd_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, load_finished,
    input  rd0_req, rd0_addr, rd1_req, rd1_addr, proc_done,
    output wr_gnt, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid, rd_data
  );
endinterface

// File: rtl/image_bram_scheduler.sv
// Frame sequencer and single-port image BRAM arbiter: loader writes a frame, then two readers share the port round-robin.
// Optional IMAGE_SCHED_OVERLAP_EN: readers may use idle write cycles during LOAD (writer keeps priority).
module image_bram_scheduler #(
  parameter  int WIDTH      = 1280,
  parameter  int HEIGHT     = 720,
  parameter  int IMAGE_SIZE = WIDTH * HEIGHT,
  localparam int ADDR_W     = $clog2(IMAGE_SIZE)
) (
  input  logic                     clock,
  input  logic                     reset,
  image_bram_scheduler_if.slave    bus,
  output logic                     bram_en,
  output logic                     bram_we,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [23:0]              bram_wdata,
  input  logic [23:0]              bram_rdata,
  output logic [1:0]               phase,
  output logic [15:0]              frame_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_PROCESS = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              ptr_reg, ptr_next;
  logic [15:0]       frame_count_reg;
  logic              wr_gnt;
  logic              rd_window;
  logic [1:0]        rd_req;
  logic [1:0]        rd_gnt;
  logic [1:0]        rd_valid;
  logic [ADDR_W-1:0] rd_addr [2];

  assign rd_req     = {bus.rd1_req, bus.rd0_req};
  assign rd_addr[0] = bus.rd0_addr;
  assign rd_addr[1] = bus.rd1_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      ptr_reg         <= 1'b0;
      frame_count_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (state_reg == S_DONE)
        frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    wr_gnt     = 1'b0;
    rd_window  = 1'b0;
    rd_gnt     = 2'b00;
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;

    case (state_reg)
      S_IDLE: begin
        wr_gnt = bus.wr_req;
        if (bus.wr_req)
          state_next = S_LOAD;
      end
      S_LOAD: begin
        wr_gnt = bus.wr_req;
`ifdef IMAGE_SCHED_OVERLAP_EN
        rd_window = !bus.wr_req;
`else
        rd_window = 1'b0;
`endif
        if (bus.load_finished)
          state_next = S_PROCESS;
      end
      S_PROCESS: begin
        rd_window = 1'b1;
        if (bus.proc_done)
          state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase

    // Preferred reader first, otherwise whoever is asking.
    if (rd_window) begin
      if (rd_req[ptr_reg])
        rd_gnt[ptr_reg] = 1'b1;
      else if (rd_req[!ptr_reg])
        rd_gnt[!ptr_reg] = 1'b1;
    end

    // Async reset must silence the port immediately, not just at the next edge.
    if (reset) begin
      wr_gnt = 1'b0;
      rd_gnt = 2'b00;
    end

    if (wr_gnt) begin
      bram_en    = 1'b1;
      bram_we    = 1'b1;
      bram_addr  = bus.wr_addr;
      bram_wdata = bus.wr_data;
    end else if (rd_gnt[0]) begin
      bram_en   = 1'b1;
      bram_addr = rd_addr[0];
    end else if (rd_gnt[1]) begin
      bram_en   = 1'b1;
      bram_addr = rd_addr[1];
    end

    if (rd_gnt[0])
      ptr_next = 1'b1;
    else if (rd_gnt[1])
      ptr_next = 1'b0;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_valid
    logic valid_reg;
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        valid_reg <= 1'b0;
      else
        valid_reg <= rd_gnt[gi];
    end
    assign rd_valid[gi] = valid_reg;
  end

  assign bus.wr_gnt    = wr_gnt;
  assign bus.rd0_gnt   = rd_gnt[0];
  assign bus.rd1_gnt   = rd_gnt[1];
  assign bus.rd0_valid = rd_valid[0];
  assign bus.rd1_valid = rd_valid[1];
  assign bus.rd_data   = bram_rdata;
  assign phase         = state_reg;
  assign frame_count   = frame_count_reg;

endmodule

// File: doc/image_bram_scheduler.md
# image_bram_scheduler

Frame-level sequencer and port arbiter for the single-port image BRAM in the Hough transform pipeline. The loader writes a full frame, then two downstream readers (edge/gradient stage and Hough voting stage) share the port round-robin until processing completes. The block sits between the image loader and the BRAM, and between the BRAM and the processing stages. It owns the BRAM enable, write-enable, address and write-data lines, and reports frame phase and frame count.

## Interface
- WIDTH, 1280, image width in pixels
- HEIGHT, 720, image height in pixels
- IMAGE_SIZE, WIDTH*HEIGHT, pixels per frame; ADDR_W = $clog2(IMAGE_SIZE)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- wr_req / wr_addr / wr_data  in  1 / ADDR_W / 24  loader write request, address, pixel
- load_finished  in  1  loader last-pixel pulse
- wr_gnt  out  1  write accepted this cycle
- rd0_req / rd0_addr  in  1 / ADDR_W  reader 0 request and address
- rd1_req / rd1_addr  in  1 / ADDR_W  reader 1 request and address
- rd0_gnt, rd1_gnt  out  1  read accepted this cycle
- rd0_valid, rd1_valid  out  1  rd_data valid for that reader
- rd_data  out  24  read data, equal to bram_rdata
- proc_done  in  1  processing-complete pulse from the Hough stage
- bram_en / bram_we / bram_addr / bram_wdata  out  1 / 1 / ADDR_W / 24  BRAM port
- bram_rdata  in  24  BRAM read data, 1-cycle latency
- phase  out  2  0 IDLE, 1 LOAD, 2 PROCESS, 3 DONE
- frame_count  out  16  completed frames

## Operation
- IDLE:
  - wr_req is granted combinationally, and the state moves to LOAD next cycle.
  - Readers are never granted.
- LOAD:
  - wr_gnt = wr_req. The BRAM port carries the write: bram_en=1, bram_we=1, bram_addr=wr_addr, bram_wdata=wr_data.
  - Readers are not granted (see Configuration).
  - A load_finished pulse moves the state to PROCESS; the write in that same cycle is still granted.
- PROCESS:
  - wr_gnt=0; the writer stalls.
  - Round-robin between readers. A 1-bit pointer selects the preferred reader.
  - With a single requester, that requester wins. With both requesting, the preferred reader wins.
  - The pointer is set to the other reader after every grant.
  - Granted: bram_en=1, bram_we=0, bram_addr = the winner's address.
  - A proc_done pulse moves the state to DONE.
- DONE:
  - Lasts one cycle with no grants.
  - frame_count increments, wrapping 65535→0.
  - Next state is IDLE.
- Ignored events: load_finished outside LOAD; proc_done outside PROCESS.
- Simultaneous events: proc_done together with a grant still completes the grant and its valid.
- No grant: bram_en=0, bram_we=0, bram_addr=0, bram_wdata=0.

## Timing
- Grants are combinational from the request and the current state. There is no backpressure beyond the grant.
- rdN_valid is a register: it goes high the cycle after rdN_gnt. rd_data = bram_rdata in that cycle.
- Back-to-back reads give one valid per cycle.
- Phase changes take effect the cycle after the triggering pulse.
- Reset, including mid-frame:
  - State IDLE, phase 0, frame_count 0, pointer to reader 0.
  - rd0_valid and rd1_valid cleared, even if a read is in flight.
  - All grants and BRAM outputs forced to 0 while reset is high.

## Configuration
- IMAGE_SCHED_OVERLAP_EN defined:
  - In LOAD, any cycle with wr_req=0 grants readers using the same round-robin rules.
  - The writer always has priority.
- IMAGE_SCHED_OVERLAP_EN undefined: readers are never granted in LOAD.

## Test plan
- Reset, then wr_req=1 with wr_addr 0,1,2,3 and data 0xA0A0A0+n:
  - wr_gnt=1 and bram_we=1 each cycle.
  - phase 0→1 after the first cycle.
- In LOAD, pulse load_finished, then hold wr_req=1:
  - phase=2 next cycle.
  - wr_gnt=0 and bram_en=0 afterwards.
- In PROCESS, hold rd0_req and rd1_req with addresses 10 and 20:
  - Grants alternate rd0, rd1, rd0, …, and bram_addr alternates 10, 20, ….
  - The matching rdN_valid follows one cycle later, carrying bram_rdata.
- Pulse proc_done in PROCESS:
  - phase=3 for exactly one cycle, then phase=0.
  - frame_count 0→1.
- Assert reset in the cycle after rd0_gnt:
  - rd0_valid=0 next cycle.
  - phase=0, frame_count=0; after release, a fresh frame loads from address 0.
- In LOAD with wr_req=0 and rd1_req=1 at address 5:
  - rd1_gnt=1 and bram_addr=5 with the macro defined.
  - rd1_gnt=0 and bram_en=0 without it.
